// File: rtl/dcache_pkg.sv
// Shared sizing constants and FSM state encoding for the direct-mapped data cache.
// Geometry defaults to 16 lines x 4 words on a 22-bit word address.
package dcache_pkg;
    localparam int ADDR_W   = 22;
    localparam int DATA_W   = 32;
    localparam int LINES    = 16;
    localparam int WORDS    = 4;
    localparam int INDEX_W  = $clog2(LINES);
    localparam int OFFSET_W = $clog2(WORDS);
    localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;
endpackage

// File: rtl/dcache_ctrl_if.sv
// Pipeline-side load/store port plus backing-memory request port of the data cache.
// slave is the cache's view; master is the pipeline/memory environment's view.
interface dcache_ctrl_if;
    import dcache_pkg::*;

    logic              re;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              cache_hit;
    logic              stall;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  re, we, addr, wdata, mem_ack, mem_rdata,
        output rdata, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output re, we, addr, wdata, mem_ack, mem_rdata,
        input  rdata, cache_hit, stall, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_array.sv
// Tag/valid/data storage: combinational lookup, synchronous word/tag write, valid clear.
// No handshake; the controller qualifies every write.
module dcache_array import dcache_pkg::*; #(
    parameter int LINES = dcache_pkg::LINES,
    parameter int WORDS = dcache_pkg::WORDS,
    parameter int TAG_W = dcache_pkg::TAG_W
) (
    input  logic                     clk,
    input  logic                     clr,
    input  logic [$clog2(LINES)-1:0] index,
    input  logic [$clog2(WORDS)-1:0] offset,
    input  logic [TAG_W-1:0]         tag,
    output logic                     hit,
    output logic [DATA_W-1:0]        rdata,
    input  logic                     wr_en,
    input  logic [$clog2(WORDS)-1:0] wr_offset,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     tag_we
);
    logic [TAG_W-1:0]  tags  [LINES];
    logic [DATA_W-1:0] data  [LINES][WORDS];
    logic [LINES-1:0]  valid;

    // Clear wins over a same-cycle line install so an abandoned fill never becomes valid.
    always_ff @(posedge clk) begin
        if (clr) begin
            valid <= '0;
        end else if (tag_we) begin
            valid[index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (tag_we) begin
            tags[index] <= tag;
        end
        if (wr_en) begin
            data[index][wr_offset] <= wr_data;
        end
    end

    assign hit   = valid[index] && (tags[index] == tag);
    assign rdata = data[index][offset];
endmodule

// File: rtl/dcache_ctrl.sv
// Write-through, no-write-allocate direct-mapped data cache controller.
// Hits return same cycle; misses/stores hold stall until memory acks, then one DONE cycle.
module dcache_ctrl import dcache_pkg::*; #(
    parameter int LINES = dcache_pkg::LINES,
    parameter int WORDS = dcache_pkg::WORDS
) (
    input  logic        clk,
    input  logic        rst_n,
    dcache_ctrl_if.slave bus
);
    localparam int IX_W = $clog2(LINES);
    localparam int OF_W = $clog2(WORDS);
    localparam int TG_W = ADDR_W - IX_W - OF_W;

    state_t              state;
    logic [OF_W-1:0]     cnt;
    logic [TG_W-1:0]     tag;
    logic [IX_W-1:0]     index;
    logic [OF_W-1:0]     offset;
    logic                hit;
    logic                fill_ack;
    logic                write_ack;
    logic                last;
    logic                wr_en;
    logic [OF_W-1:0]     wr_offset;
    logic [DATA_W-1:0]   wr_data;
    logic                tag_we;

    assign tag    = bus.addr[ADDR_W-1 -: TG_W];
    assign index  = bus.addr[OF_W +: IX_W];
    assign offset = bus.addr[OF_W-1:0];

    // mem_req is always high in FILL/WRITE, so ack is only honoured there.
    assign fill_ack  = (state == FILL)  && bus.mem_ack;
    assign write_ack = (state == WRITE) && bus.mem_ack;
    assign last      = (cnt == OF_W'(WORDS - 1));

    assign wr_en     = rst_n && (fill_ack || (write_ack && hit));
    assign wr_offset = (state == FILL) ? cnt : offset;
    assign wr_data   = (state == FILL) ? bus.mem_rdata : bus.wdata;
    assign tag_we    = rst_n && fill_ack && last;

    dcache_array #(
        .LINES (LINES),
        .WORDS (WORDS),
        .TAG_W (TG_W)
    ) u_array (
        .clk       (clk),
        .clr       (!rst_n),
        .index     (index),
        .offset    (offset),
        .tag       (tag),
        .hit       (hit),
        .rdata     (bus.rdata),
        .wr_en     (wr_en),
        .wr_offset (wr_offset),
        .wr_data   (wr_data),
        .tag_we    (tag_we)
    );

    assign bus.cache_hit = hit;
    assign bus.stall     = (state == FILL) || (state == WRITE) ||
                           ((state == IDLE) && (bus.we || (bus.re && !hit)));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            bus.mem_req   <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.we) begin
                        state         <= WRITE;
                        bus.mem_req   <= 1'b1;
                        bus.mem_we    <= 1'b1;
                        bus.mem_addr  <= bus.addr;
                        bus.mem_wdata <= bus.wdata;
                    end else if (bus.re && !hit) begin
                        state        <= FILL;
                        cnt          <= '0;
                        bus.mem_req  <= 1'b1;
                        bus.mem_we   <= 1'b0;
                        bus.mem_addr <= {tag, index, {OF_W{1'b0}}};
                    end
                end
                FILL: begin
                    if (bus.mem_ack) begin
                        if (last) begin
                            state       <= DONE;
                            bus.mem_req <= 1'b0;
                        end else begin
                            cnt          <= cnt + 1'b1;
                            bus.mem_addr <= {tag, index, cnt + 1'b1};
                        end
                    end
                end
                WRITE: begin
                    if (bus.mem_ack) begin
                        state       <= DONE;
                        bus.mem_req <= 1'b0;
                        bus.mem_we  <= 1'b0;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/dcache_ctrl.md
DCACHE_CTRL -- requirements
Module: dcache_ctrl

Interface
REQ-001 Parameter LINES, default 16, number of direct-mapped cache lines.
REQ-002 Parameter WORDS, default 4, 32-bit words per line.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 re  input  1  MEM-stage load request.
REQ-006 we  input  1  MEM-stage store request.
REQ-007 addr  input  22  word address: tag[21:6], index[5:2], offset[1:0] at defaults.
REQ-008 wdata  input  32  store data.
REQ-009 rdata  output  32  load data, valid when re=1 and stall=0.
REQ-010 cache_hit  output  1  valid & tag match for addr, combinational.
REQ-011 stall  output  1  freezes PC and all pipeline registers while 1.
REQ-012 mem_req  output  1  backing-memory request.
REQ-013 mem_we  output  1  1 = write, 0 = read.
REQ-014 mem_addr  output  22  backing-memory word address.
REQ-015 mem_wdata  output  32  backing-memory write data.
REQ-016 mem_ack  input  1  one-cycle completion pulse per word.
REQ-017 mem_rdata  input  32  read data, valid with mem_ack.

Function
REQ-018 FSM states: IDLE, FILL, WRITE, DONE.
REQ-019 IDLE, re=1, we=0, hit: rdata = line word same cycle; stall=0; stay IDLE.
REQ-020 IDLE, re=1, we=0, miss: stall=1 same cycle; go FILL; fill counter=0.
REQ-021 FILL: mem_req=1, mem_we=0, mem_addr={tag,index,counter}; each mem_ack writes mem_rdata into word[counter] and increments counter.
REQ-022 FILL, ack on counter=WORDS-1: set valid, write tag, go DONE.
REQ-023 IDLE, we=1: go WRITE, stall=1 (write-through, no-write-allocate); we has priority over simultaneous re, and re is ignored.
REQ-024 WRITE: mem_req=1, mem_we=1, mem_addr=addr, mem_wdata=wdata; on mem_ack, if hit, update cached word with wdata; go DONE.
REQ-025 DONE: stall=0 for exactly one cycle; rdata = line word for addr; go IDLE unconditionally.
REQ-026 stall = (state is FILL or WRITE) or (state is IDLE and (we or (re and not hit))); stall=0 in DONE.
REQ-027 mem_req stays high with stable mem_addr/mem_we/mem_wdata until mem_ack; mem_req=0 in IDLE and DONE.
REQ-028 mem_ack while mem_req=0 is ignored.
REQ-029 addr, re, we, wdata are held stable by the pipeline while stall=1.
REQ-030 Fill to a valid line with a different tag replaces it; no writeback, because the cache is write-through.
REQ-031 Fill latency with single-cycle ack: request cycle + 4 ack cycles + DONE; data returned in the DONE cycle.

Reset
REQ-032 When rst_n=0 at a clock edge: state=IDLE, all valid bits=0, fill counter=0.
REQ-033 Outputs after reset: mem_req=0, mem_we=0, stall=0 (with re=we=0), cache_hit=0.
REQ-034 Reset during FILL/WRITE abandons the transaction; the partial line stays invalid and mem_req=0 from the next cycle.
REQ-035 Data and tag arrays are not reset.

Structure
REQ-036 Package dcache_pkg holds LINES, WORDS, TAG_W, INDEX_W, OFFSET_W and the FSM state enum.
REQ-037 Sub-module dcache_array holds the tag/valid/data storage, with combinational read and synchronous write plus a valid-clear port.
REQ-038 dcache_ctrl holds the FSM, fill counter and stall/mem handshake logic.

Verification
REQ-039 Reset, then re addr=0x000040 (cold miss) -> stall=1, four mem reads 0x40..0x43, DONE returns word 0, next re 0x000041 hits with stall=0.
REQ-040 Store addr=0x000041 wdata=0xDEADBEEF to a resident line -> one mem write, stall until ack, then load 0x41 hits with 0xDEADBEEF.
REQ-041 Store to a non-resident addr=0x000100 -> mem write issued; a subsequent load 0x100 misses (no allocate).
REQ-042 Load 0x000040 then load 0x000440 (same index, new tag) -> second load refills; load 0x40 misses again.
REQ-043 re=we=1 addr=0x80 -> write only, no fill; mem_ack delayed 5 cycles -> mem_req and mem_addr stable throughout.
REQ-044 rst_n=0 after the 2nd fill ack -> mem_req=0 next cycle; load of the same line misses and refills all 4 words.
